dma_channel_arbiter: RTL
========================

// Module: dma_channel_arbiter
// PURPOSE
//  Shares one dma_load_store engine between NUM_CH requesters (CPU, accelerators).
//  Per-channel descriptor handshake, round-robin arbitration, and sequencing of one transfer
//  at a time through the engine. Completion is detected by counting engine valid_out beats.
//  Reports per-channel done/error.
// PARAMETERS
//  NUM_CH      4   number of requesting channels (2..8)
//  ADDR_WIDTH  12  engine start address width
//  SIZE_WIDTH  8   transfer length (beats) width
//  MODE_WIDTH  4   engine mode width; 4'b0001=load, 4'b0010=store
//  TIMEOUT     255 watchdog limit in cycles (used only with DMA_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1                      system clock
//  rst           in   1                      synchronous active-high reset
//  req_valid     in   NUM_CH                 channel i has a descriptor pending
//  req_addr      in   NUM_CH*ADDR_WIDTH      start addr, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_size      in   NUM_CH*SIZE_WIDTH      beat count, same packing
//  req_mode      in   NUM_CH*MODE_WIDTH      mode, same packing
//  req_ack       out  NUM_CH                 one-hot 1-cycle pulse: descriptor accepted
//  done          out  NUM_CH                 one-hot 1-cycle pulse: transfer finished
//  err           out  NUM_CH                 one-hot 1-cycle pulse, coincident with done: rejected/aborted
//  busy          out  1                      engine owned by a channel
//  grant_id      out  $clog2(NUM_CH)         current/last granted channel
//  eng_valid_in  out  1                      to engine valid_in
//  eng_addr      out  ADDR_WIDTH             to engine src_dst_addr
//  eng_size      out  SIZE_WIDTH             to engine size
//  eng_mode      out  MODE_WIDTH             to engine mode
//  eng_valid_out in   1                      from engine: one beat completed
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; RR pointer=0; beat counter=0; latched descriptor=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE (IDLE -> DONE for rejects).
//  IDLE: if |req_valid, winner = first set bit searching up from RR pointer, wrapping at NUM_CH.
//    Same edge: latch winner's addr/size/mode; grant_id<=winner; req_ack[winner]=1 for 1 cycle.
//    Legal mode and size!=0 -> BUSY. Otherwise -> DONE with err.
//  BUSY: eng_valid_in=1 and eng_* = latched descriptor, held stable the whole state.
//    busy=1. Each eng_valid_out increments beat counter (SIZE_WIDTH bits).
//    eng_valid_out when counter==size-1 -> DONE. Beats arriving in IDLE/DONE are ignored.
//  DONE: eng_valid_in=0; done[grant_id]=1 (err too if rejected/aborted); counter cleared;
//    RR pointer <= grant_id+1 (mod NUM_CH) -> IDLE.
//  Latency: req_valid seen -> req_ack next edge -> eng_valid_in the cycle after.
//    Last beat -> done next cycle; back-to-back grant one cycle after done.
//  Requester keeps req_valid/desc stable until req_ack. Deasserting before ack withdraws
//    the request. Descriptor is sampled only at the ack edge.
//  req_valid changes during BUSY do not affect the transfer in flight.
//  Same channel re-requesting while others wait: RR guarantees every waiting channel is
//    granted within NUM_CH transfers.
//  Size=1: single beat; done after the first eng_valid_out. Size=2^SIZE_WIDTH-1: no wrap.
//  rst mid-transfer: immediate return to reset state; no done/err pulse; eng_valid_in drops
//    at the reset edge.
// CONFIGURATION
//  DMA_ARB_TIMEOUT_EN defined: BUSY cycle counter, cleared on every eng_valid_out.
//    Reaching TIMEOUT -> DONE with err[grant_id]=1 (abort, remaining beats discarded).
//  Not defined: no watchdog; BUSY waits indefinitely for beats; TIMEOUT unused.
// TESTING
//  1 ch0 req addr=0x100 size=8 mode=0001, engine returns 8 beats -> ack[0] pulse, eng_addr=0x100,
//    eng_valid_in high 8 beat-cycles, done[0] 1 cycle after 8th beat, err=0.
//  2 ch0..ch3 all request same cycle, RR ptr=0 -> grant order 0,1,2,3; ch0 re-requests after
//    done -> next grant after ch3 is 0.
//  3 ch2 size=0, or ch2 mode=4'b0100 -> ack[2], then done[2]=err[2]=1 next cycle; eng_valid_in
//    never asserted.
//  4 rst asserted after 3 of 8 beats -> all outputs 0 next edge, no done; new ch1 request
//    afterwards runs normally from RR ptr 0.
//  5 size=1 then size=255 back to back -> done after 1 beat, then after exactly 255 beats.
//  6 (DMA_ARB_TIMEOUT_EN, TIMEOUT=20) grant size=4, engine stalls after 2 beats -> done=err=1
//    20 cycles after last beat; without the macro busy stays high.

Source files
------------

// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter sharing one DMA load/store engine between NUM_CH requesting channels.
// Defining DMA_ARB_TIMEOUT_EN adds a BUSY-state watchdog that aborts a stalled transfer after TIMEOUT cycles.
module dma_channel_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int SIZE_WIDTH = 8,
    parameter int MODE_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*SIZE_WIDTH-1:0] req_size,
    input  logic [NUM_CH*MODE_WIDTH-1:0] req_mode,
    output logic [NUM_CH-1:0]            req_ack,
    output logic [NUM_CH-1:0]            done,
    output logic [NUM_CH-1:0]            err,
    output logic                         busy,
    output logic [$clog2(NUM_CH)-1:0]    grant_id,
    output logic                         eng_valid_in,
    output logic [ADDR_WIDTH-1:0]        eng_addr,
    output logic [SIZE_WIDTH-1:0]        eng_size,
    output logic [MODE_WIDTH-1:0]        eng_mode,
    input  logic                         eng_valid_out
);
    localparam int ID_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ID_W-1:0]         rr_ptr_reg, grant_id_reg, winner, rr_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [SIZE_WIDTH-1:0]   size_reg, cnt_reg;
    logic [MODE_WIDTH-1:0]   mode_reg;
    logic                    err_reg;
    logic                    has_req, desc_ok, last_beat, timeout_hit;

    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_CH];
    logic [SIZE_WIDTH-1:0]   size_arr [NUM_CH];
    logic [MODE_WIDTH-1:0]   mode_arr [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign size_arr[gi] = req_size[gi*SIZE_WIDTH +: SIZE_WIDTH];
            assign mode_arr[gi] = req_mode[gi*MODE_WIDTH +: MODE_WIDTH];
        end
    endgenerate

    // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
    always_comb begin
        int          idx;
        logic [ID_W-1:0] idx_w;
        winner = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_w = idx[ID_W-1:0];
            if (req_valid[idx_w]) begin
                winner = idx_w;
            end
        end
    end

    assign has_req   = |req_valid;
    assign desc_ok   = (size_arr[winner] != '0) &&
                       ((mode_arr[winner] == MODE_WIDTH'(1)) || (mode_arr[winner] == MODE_WIDTH'(2)));
    assign last_beat = eng_valid_out && (cnt_reg == size_reg - SIZE_WIDTH'(1));
    assign rr_next   = (grant_id_reg == ID_W'(NUM_CH - 1)) ? '0 : grant_id_reg + 1'b1;
    assign grant_id  = grant_id_reg;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_reg;
    assign timeout_hit = !eng_valid_out && (wd_reg == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state_reg != BUSY || eng_valid_out) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        req_ack      = '0;
        done         = '0;
        err          = '0;
        busy         = 1'b0;
        eng_valid_in = 1'b0;
        eng_addr     = '0;
        eng_size     = '0;
        eng_mode     = '0;
        case (state_reg)
            IDLE: begin
                // No handshake while reset is held: nothing would be latched.
                if (has_req && !rst) begin
                    req_ack[winner] = 1'b1;
                    state_next      = desc_ok ? BUSY : DONE;
                end
            end
            BUSY: begin
                busy         = 1'b1;
                eng_valid_in = 1'b1;
                eng_addr     = addr_reg;
                eng_size     = size_reg;
                eng_mode     = mode_reg;
                if (last_beat || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done[grant_id_reg] = 1'b1;
                err[grant_id_reg]  = err_reg;
                state_next         = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            addr_reg     <= '0;
            size_reg     <= '0;
            mode_reg     <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (has_req) begin
                        grant_id_reg <= winner;
                        addr_reg     <= addr_arr[winner];
                        size_reg     <= size_arr[winner];
                        mode_reg     <= mode_arr[winner];
                        err_reg      <= !desc_ok;
                        cnt_reg      <= '0;
                    end
                end
                BUSY: begin
                    if (eng_valid_out) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    if (timeout_hit) begin
                        err_reg <= 1'b1;
                    end
                end
                DONE: begin
                    cnt_reg    <= '0;
                    rr_ptr_reg <= rr_next;
                end
                default: ;
            endcase
        end
    end
endmodule
